uart_tx_fifo_ctrl: RTL and testbench

//  Transmit holding FIFO and launch controller directly upstream of UART_TX.

---
 rtl/uart_tx_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_ctrl : transmit holding FIFO and launch pacing for UART_TX     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Rst,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  input  logic          i_TX_En,
  input  logic          i_Flush,
  input  logic          i_TX_Done,
  output logic          o_TX_DV,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_RDY,
  output logic          o_TX_EMT,
  output logic [AW:0]   o_Count,
  output logic          o_Wr_Drop
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [AW:0]   count_q,   count_d;
  logic          tx_dv_q,   tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          wr_drop_q, wr_drop_d;
  logic [7:0]    mem_q [DEPTH];

  logic pop;
  logic push;

  always_comb begin
    pop  = (state_q == S_IDLE) && i_TX_En && (count_q != '0) && !i_Flush;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push = i_Wr_DV && !i_Flush && ((count_q != C_FULL) || pop);

    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wr_drop_d = i_Wr_DV && !i_Flush && (count_q == C_FULL) && !pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d   = S_LAUNCH;
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
        end
      end
      S_LAUNCH: state_d = S_BUSY;
      S_BUSY:   if (i_TX_Done) state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (i_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      if (push && !pop)      count_d = count_q + C_CNT_ONE;
      else if (pop && !push) count_d = count_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;
  assign o_TX_RDY  = (count_q != C_FULL);
  assign o_TX_EMT  = (count_q == '0) && (state_q == S_IDLE);
  assign o_Count   = count_q;
  assign o_Wr_Drop = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo_ctrl : bench for uart_tx_fifo_ctrl with a fake UART_TX      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo_ctrl;

  localparam int DEPTH    = 4;
  localparam int UART_LEN = 6;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Wr_DV = 1'b0;
  logic [7:0] i_Wr_Byte = 8'h00;
  logic       i_TX_En = 1'b0;
  logic       i_Flush = 1'b0;
  logic       i_TX_Done = 1'b0;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       o_TX_RDY;
  logic       o_TX_EMT;
  logic [2:0] o_Count;
  logic       o_Wr_Drop;

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .i_Clock   (clk),
    .i_Rst     (i_Rst),
    .i_Wr_DV   (i_Wr_DV),
    .i_Wr_Byte (i_Wr_Byte),
    .i_TX_En   (i_TX_En),
    .i_Flush   (i_Flush),
    .i_TX_Done (i_TX_Done),
    .o_TX_DV   (o_TX_DV),
    .o_TX_Byte (o_TX_Byte),
    .o_TX_RDY  (o_TX_RDY),
    .o_TX_EMT  (o_TX_EMT),
    .o_Count   (o_Count),
    .o_Wr_Drop (o_Wr_Drop)
  );

  int total = 0;
  int bad   = 0;
  int pcyc  = 0;
  int drop_seen = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus a timeline of when the launcher may act again.
  logic [7:0] mq[$];
  bit         m_valid = 0;
  bit         m_inflight = 0;
  int         m_idle_from = 0;
  int         m_launch = 0;
  int         mcyc = 0;
  logic       m_dv = 1'b0;
  logic       m_drop = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always @(negedge clk) begin
    bit   launch;
    bit   done_ok;
    logic e_rdy;
    logic e_emt;
    if (o_Wr_Drop === 1'b1) drop_seen++;
    if (m_valid) begin
      e_rdy = (mq.size() != DEPTH);
      e_emt = (mq.size() == 0) && !m_inflight && (mcyc >= m_idle_from);
      total++;
      if (o_TX_DV !== m_dv || o_TX_Byte !== m_byte || o_TX_RDY !== e_rdy ||
          o_TX_EMT !== e_emt || o_Count !== 3'(mq.size()) || o_Wr_Drop !== m_drop) begin
        bad++;
        $display("FAIL model t=%0t got dv=%b byte=%h rdy=%b emt=%b cnt=%0d drop=%b expected dv=%b byte=%h rdy=%b emt=%b cnt=%0d drop=%b",
                 $time, o_TX_DV, o_TX_Byte, o_TX_RDY, o_TX_EMT, o_Count, o_Wr_Drop,
                 m_dv, m_byte, e_rdy, e_emt, mq.size(), m_drop);
      end
    end
    if (i_Rst) begin
      mq.delete();
      m_valid = 1;
      m_inflight = 0;
      m_idle_from = 0;
      m_dv = 1'b0;
      m_drop = 1'b0;
      m_byte = 8'h00;
    end else begin
      launch  = !m_inflight && (mcyc >= m_idle_from) && i_TX_En && (mq.size() != 0) && !i_Flush;
      done_ok = i_TX_Done && m_inflight && (mcyc >= m_launch + 2);
      if (done_ok) begin
        m_inflight = 0;
        m_idle_from = mcyc + 2;
      end
      m_dv = launch;
      m_drop = 1'b0;
      if (launch) begin
        m_byte = mq.pop_front();
        m_inflight = 1;
        m_launch = mcyc;
      end
      if (i_Flush) mq.delete();
      else if (i_Wr_DV) begin
        if (mq.size() < DEPTH) mq.push_back(i_Wr_Byte);
        else m_drop = 1'b1;
      end
    end
    mcyc++;
  end

  // Fake UART_TX: records each launch and answers with a done pulse UART_LEN cycles later.
  int         uart_cnt = 0;
  bit         uart_abort = 0;
  bit         manual_done = 0;
  logic [7:0] sent[$];
  int         dv_cyc[$];
  int         done_cyc[$];

  initial begin
    bit w;
    forever begin
      @(posedge clk);
      #1;
      w = 0;
      if (uart_abort) uart_cnt = 0;
      else if (uart_cnt != 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          w = 1;
          done_cyc.push_back(pcyc);
        end
      end
      if (o_TX_DV === 1'b1) begin
        sent.push_back(o_TX_Byte);
        dv_cyc.push_back(pcyc);
        if (!uart_abort) uart_cnt = UART_LEN;
      end
      i_TX_Done = w | manual_done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    i_Wr_DV = 1'b1;
    i_Wr_Byte = b;
    tick(1);
    i_Wr_DV = 1'b0;
  endtask

  task automatic wait_emt(input string name, input int maxc);
    int k;
    k = 0;
    while (!(o_TX_EMT === 1'b1 && uart_cnt == 0)) begin
      tick(1);
      k++;
      if (k > maxc) begin
        total++;
        bad++;
        $display("FAIL %s timeout: got emt=%b expected emt=1 within %0d cycles", name, o_TX_EMT, maxc);
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int wc;
    int d0;

    // Reset state
    tick(3);
    i_Rst = 1'b0;
    chk("reset_outs", {o_TX_DV, o_TX_Byte, o_TX_RDY, o_TX_EMT, o_Count, o_Wr_Drop},
        {1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0});

    // Single byte, launch latency of two cycles
    i_TX_En = 1'b1;
    base = sent.size();
    wc = pcyc;
    wr(8'hA5);
    wait_emt("t1", 40);
    chk("t1_nsent", sent.size() - base, 1);
    chk("t1_byte", sent[base], 8'hA5);
    chk("t1_latency", dv_cyc[base] - wc, 2);

    // Fill to full with transmitter off, fifth write dropped
    i_TX_En = 1'b0;
    base = sent.size();
    for (int i = 1; i <= 4; i++) wr(8'(i));
    chk("t2_rdy_full", o_TX_RDY, 1'b0);
    d0 = drop_seen;
    wr(8'h05);
    tick(1);
    chk("t2_drop", drop_seen - d0, 1);
    chk("t2_count", o_Count, 3'd4);
    i_TX_En = 1'b1;
    wait_emt("t2", 200);
    chk("t2_nsent", sent.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("t2_order", sent[base + i], 8'(i + 1));

    // Held queue, then released with exact inter-byte spacing
    i_TX_En = 1'b0;
    base = sent.size();
    dbase = done_cyc.size();
    wr(8'h10);
    wr(8'h11);
    wr(8'h12);
    tick(5);
    chk("t3_nolaunch", sent.size() - base, 0);
    chk("t3_count", o_Count, 3'd3);
    i_TX_En = 1'b1;
    wait_emt("t3", 200);
    chk("t3_nsent", sent.size() - base, 3);
    chk("t3_last", sent[base + 2], 8'h12);
    for (int i = 1; i < 3; i++) chk("t3_gap", dv_cyc[base + i] - done_cyc[dbase + i - 1], 3);

    // Flush while a byte is in flight; same-cycle write is silently discarded
    base = sent.size();
    wr(8'h20);
    wr(8'h21);
    wr(8'h22);
    wr(8'h23);
    wr(8'h24);
    chk("t4_full", o_Count, 3'd4);
    d0 = drop_seen;
    i_Flush = 1'b1;
    i_Wr_DV = 1'b1;
    i_Wr_Byte = 8'h25;
    tick(1);
    i_Flush = 1'b0;
    i_Wr_DV = 1'b0;
    chk("t4_flushed", o_Count, 3'd0);
    wait_emt("t4", 200);
    chk("t4_nodrop", drop_seen - d0, 0);
    chk("t4_nsent", sent.size() - base, 1);
    chk("t4_byte", sent[base], 8'h20);

    // Write into a full FIFO in the same cycle as a pop
    i_TX_En = 1'b0;
    base = sent.size();
    for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i));
    i_TX_En = 1'b1;
    wr(8'h3C);
    chk("t5_count", o_Count, 3'd4);
    chk("t5_nodrop", o_Wr_Drop, 1'b0);
    wait_emt("t5", 300);
    chk("t5_nsent", sent.size() - base, 5);
    chk("t5_first", sent[base], 8'h30);
    chk("t5_last", sent[base + 4], 8'h3C);

    // Reset during BUSY, then a stray done must not launch anything
    base = sent.size();
    wr(8'h40);
    wr(8'h41);
    wr(8'h42);
    tick(3);
    chk("t6_queued", o_Count, 3'd2);
    uart_abort = 1;
    i_Rst = 1'b1;
    tick(1);
    i_Rst = 1'b0;
    chk("t6_reset_outs", {o_TX_DV, o_TX_Byte, o_TX_RDY, o_TX_EMT, o_Count, o_Wr_Drop},
        {1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0});
    manual_done = 1;
    tick(1);
    manual_done = 0;
    tick(8);
    uart_abort = 0;
    chk("t6_nsent", sent.size() - base, 1);
    chk("t6_emt", o_TX_EMT, 1'b1);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
